pixel_word_packer: RTL
======================

Name: pixel_word_packer

Overview:
- Downstream neighbour of the pixel processing stage.
- Consumes processed 8-bit pixels over a valid/ready handshake and packs them little-endian into 32-bit words for the memory/bus writer.
- Tracks pixel position within a line of LINE_PIXELS pixels.
- Closes a partial word at end of line, marking it with a byte-keep mask and a last flag.

Parameters:
- LINE_PIXELS, 32, pixels per line; legal range 1..65535; last pixel of every line closes the current word.
- CNT_W, 16, width of the line pixel counter and the stats counter.

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous reset, active-high
- in_data  in  8  processed pixel from upstream stage
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  packer can accept in_data this cycle
- out_data  out  32  packed word; lane k = bits [8k+7:8k], lane 0 = earliest pixel
- out_keep  out  4  per-lane valid mask, bit k = lane k
- out_last  out  1  word contains final pixel of a line
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- line_count  out  CNT_W  completed-line counter (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at clk edge):
  - out_valid, out_last = 0; out_data = 0; out_keep = 0; line_count = 0.
  - Lane counter and pixel counter = 0; accumulator cleared.
  - Reset mid-word discards any partial accumulation; no word is emitted.
- Handshakes: input accepted when in_valid && in_ready; output transferred when out_valid && out_ready.
- Lane counter (0..3) is the fill state.
  - A pixel "completes" a word when lane==3 or pixel_cnt==LINE_PIXELS-1.
  - Non-completing pixel: in_ready=1; byte written to accumulator lane; lane increments.
  - Completing pixel: in_ready = !out_valid || out_ready (combinational from out_ready).
- On accepting a completing pixel:
  - out_data = accumulator with this byte in its lane; unused higher lanes = 0.
  - out_keep = lanes 0..lane set; out_last = (pixel_cnt==LINE_PIXELS-1); out_valid=1.
  - Lane resets to 0. Latency: word visible the cycle after the completing byte is accepted.
- Pixel counter increments per accepted pixel; wraps LINE_PIXELS-1 -> 0.
- Stall: while out_valid && !out_ready, out_data/out_keep/out_last hold stable; up to 3 non-completing pixels may still be accepted.
- Simultaneous output transfer and completing-pixel accept: new word loaded, out_valid stays 1 (no bubble).
- Output transfer with no new word loaded: out_valid -> 0; out_data/keep/last keep their stale values.
- LINE_PIXELS=1: every pixel completes; keep=0001, last=1 each word; sustains 1 word/cycle with out_ready=1.
- No combinational path from in_valid to out_valid.

Optional Feature:
- Macro PIXEL_PACK_LINE_STATS_EN.
- Defined: line_count increments on each output transfer with out_last=1; wraps at 2^CNT_W; reset to 0.
- Undefined: line_count tied to 0; no counter flops synthesized.

Decomposition:
- Package pixel_pack_pkg:
  - Constants LANES=4, PIX_W=8, WORD_W=32.
  - Lane index typedef (2-bit).
  - Keep-mask function: lane -> mask 0001/0011/0111/1111.
- One natural sub-module: line_pixel_counter (CNT_W counter, wrap at LINE_PIXELS-1, end-of-line flag).
- Packer instantiates line_pixel_counter and holds lane FSM, accumulator and output register.

Test Plan:
- LINE_PIXELS=6, out_ready=1, pixels 01..06 back-to-back -> words 0x04030201 keep=F last=0, then 0x00000605 keep=3 last=1.
- LINE_PIXELS=8, out_ready=0 after first word -> word holds 0x04030201; pixels 05,06,07 accepted; pixel 08 sees in_ready=0 until out_ready=1. Then 0x08070605 keep=F last=1 follows with no lost byte.
- LINE_PIXELS=1, continuous in_valid, out_ready=1, pixels AA,BB,CC -> words 0x000000AA, 0x000000BB, 0x000000CC on consecutive cycles, keep=1, last=1 each.
- rst asserted after pixels 11,22 accepted, then 33,44,55,66 sent -> no word containing 11/22; first word 0x66554433 keep=F.
- LINE_PIXELS=3, random out_ready 50%, 300 pixels -> 100 words, each keep=7 last=1, data matches scoreboard in order.
- PIXEL_PACK_LINE_STATS_EN defined, LINE_PIXELS=4, 5 lines sent -> line_count=5. Undefined, same stimulus -> line_count=0.

Source files
------------

// File: rtl/pixel_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pack_pkg
// Description : Shared constants, lane types and keep-mask helper for the
//               pixel word packer.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pack_pkg;

    localparam int LANES  = 4;
    localparam int PIX_W  = 8;
    localparam int WORD_W = 32;

    // Byte lane index inside a packed word
    typedef logic [1:0] lane_t;

    // Fill state of the word being assembled: next lane to be written
    typedef enum logic [1:0] {
        LANE_0 = 2'd0,
        LANE_1 = 2'd1,
        LANE_2 = 2'd2,
        LANE_3 = 2'd3
    } lane_state_e;

    // Lanes 0..lane are populated when a word closes on this lane
    function automatic logic [LANES-1:0] keep_mask(input lane_t lane);
        logic [LANES-1:0] mask;
        case (lane)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            2'd2:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : line_pixel_counter
// Description : Position of the current pixel within a line. Counts accepted
//               pixels, wraps after LINE_PIXELS-1 and flags the last pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module line_pixel_counter #(
    parameter int LINE_PIXELS = 32,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic eol
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_PIXELS - 1);

    logic [CNT_W-1:0] cnt;

    // Pixel position: advance per accepted pixel, wrap at end of line
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= eol ? '0 : cnt + CNT_W'(1);
        end
    end

    assign eol = (cnt == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/pixel_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_word_packer
// Description : Packs 8-bit pixels little-endian into 32-bit words, closing a
//               partial word with keep mask and last flag at end of line.
//               Optional macro PIXEL_PACK_LINE_STATS_EN enables the
//               completed-line counter on line_count.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_word_packer
    import pixel_pack_pkg::*;
#(
    parameter int LINE_PIXELS = 32,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIX_W-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic [LANES-1:0]    out_keep,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    line_count
);

    lane_state_e        lane_q;
    lane_state_e        lane_d;
    lane_t              lane_idx;
    logic               eol;
    logic               completing;
    logic               accept;
    logic               load;
    logic [WORD_W-1:0]  acc_q;
    logic [WORD_W-1:0]  word_next;

    line_pixel_counter #(
        .LINE_PIXELS (LINE_PIXELS),
        .CNT_W       (CNT_W)
    ) u_line_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept),
        .eol (eol)
    );

    // Handshake, lane advance and the word as it would look with this byte
    always_comb begin
        lane_d     = lane_q;
        lane_idx   = lane_t'(lane_q);
        completing = (lane_q == LANE_3) || eol;
        // Only a closing pixel needs room in the output register
        in_ready   = completing ? (!out_valid || out_ready) : 1'b1;
        accept     = in_valid && in_ready;
        load       = accept && completing;
        word_next  = acc_q;
        word_next[{lane_idx, 3'b000} +: PIX_W] = in_data;
        if (accept) begin
            if (completing) begin
                lane_d = LANE_0;
            end else begin
                case (lane_q)
                    LANE_0:  lane_d = LANE_1;
                    LANE_1:  lane_d = LANE_2;
                    LANE_2:  lane_d = LANE_3;
                    default: lane_d = LANE_0;
                endcase
            end
        end
    end

    // Lane state register
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= LANE_0;
        end else begin
            lane_q <= lane_d;
        end
    end

    // Accumulator is cleared on close so unwritten upper lanes read as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= completing ? '0 : word_next;
        end
    end

    // Output register: load on close, drop valid on a transfer with no reload
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= word_next;
            out_keep  <= keep_mask(lane_idx);
            out_last  <= eol;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PIXEL_PACK_LINE_STATS_EN
    logic [CNT_W-1:0] line_cnt_q;

    // Count lines as their final word leaves the packer
    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt_q <= '0;
        end else if (out_valid && out_ready && out_last) begin
            line_cnt_q <= line_cnt_q + CNT_W'(1);
        end
    end

    assign line_count = line_cnt_q;
`else
    assign line_count = '0;
`endif

endmodule
`default_nettype wire
